inst_loader: RTL

- Program loader: writer side of the 256x16 instruction memory.
- Accepts a byte stream (valid/ready) carrying a word count, big-endian 16-bit instruction words and an XOR checksum. Writes each word into instruction memory at consecutive addresses from 0.
- Holds the CPU in `cpu_hold` until a load completes with a matching checksum.
- Sits between the host byte receiver and the instruction memory write port.

---
 rtl/inst_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Program loader: turns a host byte stream (count, big-endian words, XOR checksum)
// into instruction-memory writes and releases the CPU once the checksum matches.
module inst_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [CW-1:0]         words_loaded_q, words_loaded_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            csum_q, csum_d;
  logic                  xfer;

  assign xfer = rx_valid & rx_ready_q;

  always_comb begin
    state_d        = state_q;
    rx_ready_d     = rx_ready_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = done_q;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
    count_d        = count_q;
    hi_d           = hi_q;
    csum_d         = csum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d        = S_COUNT;
          rx_ready_d     = 1'b1;
          cpu_hold_d     = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          csum_d         = '0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          // A zero count byte means a full memory image.
          count_d = (rx_data == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : CW'(rx_data);
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          mem_we_d       = 1'b1;
          mem_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
          mem_wdata_d    = DATA_WIDTH'({hi_q, rx_data});
          csum_d         = csum_q ^ rx_data;
          words_loaded_d = words_loaded_q + CW'(1);
          state_d        = (words_loaded_d == count_q) ? S_CHECK : S_HI;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          rx_ready_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= HOLD_AT_RESET;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
      count_q        <= '0;
      hi_q           <= '0;
      csum_q         <= '0;
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
      count_q        <= count_d;
      hi_q           <= hi_d;
      csum_q         <= csum_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
